// File: rtl/ahb_apb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ahb_apb_pkg : shared AHB/APB encodings and bridge state type
// Revision: 1.0
// ------------------------------------------------------------------
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WWAIT  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_addr_decoder.sv
`default_nettype none
// ------------------------------------------------------------------
// apb_addr_decoder : maps an AHB address to an APB slave {hit, idx}
// Revision: 1.0
// ------------------------------------------------------------------
module apb_addr_decoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int                SLV_SHIFT = 12,
  parameter int                NUM_SLV   = 4,
  parameter int                IDX_W     = 2
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  logic [ADDR_W-1:0] w_offset;
  logic [ADDR_W-1:0] w_region;

  assign w_offset = addr - BASE_ADDR;
  assign w_region = w_offset >> SLV_SHIFT;
  // Addresses below the base wrap to huge offsets, but are rejected explicitly anyway
  assign hit      = (addr >= BASE_ADDR) && (w_region < ADDR_W'(NUM_SLV));
  assign idx      = w_region[IDX_W-1:0];

endmodule
`default_nettype wire

// File: rtl/ahb2apb_bridge_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// ahb2apb_bridge_gen : AHB-Lite to APB bridge, N slaves, Pready waits, errors
// Revision: 1.0
// ------------------------------------------------------------------
module ahb2apb_bridge_gen
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_SLV   = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
  parameter int                SLV_SHIFT = 12,
  parameter int                TIMEOUT   = 16
) (
  input  logic                      Hclk,
  input  logic                      Hresetn,
  input  logic [1:0]                Htrans,
  input  logic                      Hwrite,
  input  logic                      Hreadyin,
  input  logic [ADDR_W-1:0]         Haddr,
  input  logic [DATA_W-1:0]         Hwdata,
  output logic                      Hreadyout,
  output logic [1:0]                Hresp,
  output logic [DATA_W-1:0]         Hrdata,
  output logic [NUM_SLV-1:0]        Pselx,
  output logic                      Penable,
  output logic                      Pwrite,
  output logic [ADDR_W-1:0]         Paddr,
  output logic [DATA_W-1:0]         Pwdata,
  input  logic [NUM_SLV*DATA_W-1:0] Prdata,
  input  logic [NUM_SLV-1:0]        Pready,
  input  logic [NUM_SLV-1:0]        Pslverr
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  bridge_state_e     r_state;
  bridge_state_e     w_next_idle;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_hrdata;

  logic              w_dec_hit;
  logic [IDX_W-1:0]  w_dec_idx;
  logic              w_accept;
  logic              w_sel_ready;
  logic              w_sel_err;
  logic              w_done;
  logic              w_timeout;
  logic [DATA_W-1:0] w_sel_rdata;

  apb_addr_decoder #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .SLV_SHIFT(SLV_SHIFT),
    .NUM_SLV  (NUM_SLV),
    .IDX_W    (IDX_W)
  ) u_decoder (
    .addr(Haddr),
    .hit (w_dec_hit),
    .idx (w_dec_idx)
  );

  assign w_sel_ready = Pready[r_idx];
  assign w_sel_err   = Pslverr[r_idx];
  assign w_sel_rdata = Prdata[r_idx*DATA_W +: DATA_W];
  assign w_done      = (r_state == ST_ACCESS) && w_sel_ready && !w_sel_err;
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_accept    = Hreadyin && Hreadyout &&
                       ((Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ));

  // Completion in ACCESS reports ready in the same cycle so a pipelined
  // next address can be taken without an idle APB cycle.
  always_comb begin
    case (r_state)
      ST_IDLE, ST_ERR2: Hreadyout = 1'b1;
      ST_ACCESS:        Hreadyout = w_done;
      default:          Hreadyout = 1'b0;
    endcase
  end

  assign Hresp  = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign Hrdata = (w_done && !Pwrite) ? w_sel_rdata : r_hrdata;

  always_comb begin
    w_next_idle = ST_IDLE;
    if (w_accept) begin
      if (!w_dec_hit)  w_next_idle = ST_ERR1;
      else if (Hwrite) w_next_idle = ST_WWAIT;
      else             w_next_idle = ST_SETUP;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_hrdata <= '0;
      Pselx    <= '0;
      Penable  <= 1'b0;
      Pwrite   <= 1'b0;
      Paddr    <= '0;
      Pwdata   <= '0;
    end else begin
      if (w_accept) begin
        Paddr  <= Haddr;
        Pwrite <= Hwrite;
        r_idx  <= w_dec_idx;
      end
      case (r_state)
        ST_WWAIT: begin
          Pwdata  <= Hwdata;
          Pselx   <= NUM_SLV'(1) << r_idx;
          r_state <= ST_SETUP;
        end
        ST_SETUP: begin
          Penable <= 1'b1;
          r_cnt   <= '0;
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (w_sel_ready || w_timeout) begin
            Pselx   <= '0;
            Penable <= 1'b0;
            r_cnt   <= '0;
            if (w_done) begin
              if (!Pwrite) r_hrdata <= w_sel_rdata;
              r_state <= w_next_idle;
            end else begin
              r_state <= ST_ERR1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_ERR1: r_state <= ST_ERR2;
        default: r_state <= w_next_idle;
      endcase
      // Reads skip WWAIT, so select the slave straight from the accept
      if (w_accept && w_dec_hit && !Hwrite) Pselx <= NUM_SLV'(1) << w_dec_idx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb2apb_bridge_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ahb2apb_bridge_gen : directed + random transfers against a transfer-level model
// Revision: 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahb2apb_bridge_gen;
  import ahb_apb_pkg::*;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NS   = 4;
  localparam int          TMO  = 16;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic           Hclk;
  logic           Hresetn;
  logic [1:0]     Htrans;
  logic           Hwrite;
  logic           Hreadyin;
  logic [AW-1:0]  Haddr;
  logic [DW-1:0]  Hwdata;
  logic           Hreadyout;
  logic [1:0]     Hresp;
  logic [DW-1:0]  Hrdata;
  logic [NS-1:0]  Pselx;
  logic           Penable;
  logic           Pwrite;
  logic [AW-1:0]  Paddr;
  logic [DW-1:0]  Pwdata;
  logic [NS*DW-1:0] Prdata;
  logic [NS-1:0]  Pready;
  logic [NS-1:0]  Pslverr;

  ahb2apb_bridge_gen #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .BASE_ADDR(BASE),
    .SLV_SHIFT(12), .TIMEOUT(TMO)
  ) dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .Htrans(Htrans), .Hwrite(Hwrite),
    .Hreadyin(Hreadyin), .Haddr(Haddr), .Hwdata(Hwdata),
    .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata),
    .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
    .Pwdata(Pwdata), .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;
  assign Hreadyin = Hreadyout;

  // APB slave model: selected slave inserts cur_wait wait states; idle slaves sit ready.
  int          cur_wait;
  logic        cur_err;
  logic [DW-1:0] slv_data [NS];
  int          acc_cnt;

  always @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn)     acc_cnt <= 0;
    else if (Penable) acc_cnt <= acc_cnt + 1;
    else              acc_cnt <= 0;
  end

  always_comb begin
    Pready  = '0;
    Pslverr = '0;
    Prdata  = '0;
    for (int i = 0; i < NS; i++) begin
      Pready[i]             = Pselx[i] ? (acc_cnt >= cur_wait) : 1'b1;
      Pslverr[i]            = Pselx[i] & cur_err;
      Prdata[i*DW +: DW]    = slv_data[i];
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] rdata;
  } xfer_t;

  xfer_t       q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_hold = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_hit(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 32'd4096) < NS);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 32'd4096);
  endfunction

  function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [31:0] wd,
                               input int wt, input logic e, input logic [31:0] rd);
    xfer_t t;
    t.addr = a; t.wr = w; t.wdata = wd; t.waits = wt; t.err = e; t.rdata = rd;
    return t;
  endfunction

  // Runs every transfer in q back to back; entered just after a negedge with Hreadyout high.
  task automatic run_burst();
    xfer_t t;
    logic hit, tmo, bad, done;
    int idx, acc, exp_low, low, err_low, psel_n, pen_n, viol;
    logic [1:0] fin_resp;
    logic [31:0] fin_rdata;
    logic [NS-1:0] exp_sel;
    Htrans = HTRANS_NONSEQ; Haddr = q[0].addr; Hwrite = q[0].wr;
    for (int k = 0; k < q.size(); k++) begin
      t   = q[k];
      hit = model_hit(t.addr);
      idx = hit ? model_idx(t.addr) : 0;
      tmo = hit && (t.waits >= TMO);
      bad = !hit || tmo || t.err;
      acc = !hit ? 0 : (tmo ? TMO : t.waits + 1);
      if (!hit)     exp_low = 1;
      else if (bad) exp_low = (t.wr ? 1 : 0) + 1 + acc + 1;
      else          exp_low = (t.wr ? 1 : 0) + acc;
      exp_sel = '0;
      if (hit) exp_sel[idx] = 1'b1;

      @(posedge Hclk);
      @(negedge Hclk);
      cur_wait = t.waits; cur_err = t.err;
      for (int i = 0; i < NS; i++) slv_data[i] = $urandom;
      if (hit) slv_data[idx] = t.rdata;
      Hwdata = t.wdata;
      if (k + 1 < q.size()) begin
        Htrans = ($urandom_range(0, 1) != 0) ? HTRANS_SEQ : HTRANS_NONSEQ;
        Haddr = q[k+1].addr; Hwrite = q[k+1].wr;
      end else begin
        Htrans = ($urandom_range(0, 1) != 0) ? HTRANS_BUSY : HTRANS_IDLE;
        Haddr = $urandom; Hwrite = 1'($urandom);
      end

      low = 0; err_low = 0; psel_n = 0; pen_n = 0; viol = 0; done = 1'b0;
      fin_resp = 2'bxx; fin_rdata = 'x;
      for (int c = 0; c < 60 && !done; c++) begin
        if (c > 0) @(negedge Hclk);
        #1;
        if (Pselx !== '0) begin
          psel_n++;
          if (Pselx !== exp_sel || Paddr !== t.addr || Pwrite !== t.wr ||
              (t.wr && Pwdata !== t.wdata)) viol++;
        end
        if (Penable) pen_n++;
        if (Hreadyout === 1'b1) begin
          done = 1'b1; fin_resp = Hresp; fin_rdata = Hrdata;
        end else begin
          low++;
          if (Hresp === HRESP_ERROR) err_low++;
        end
      end
      if (!done) check("completion_bound", 1'b0, 1'b1);
      check("hready_low_cycles", low, exp_low);
      check("final_hresp", fin_resp, bad ? HRESP_ERROR : HRESP_OKAY);
      check("error_low_cycles", err_low, bad ? 1 : 0);
      check("psel_cycles", psel_n, hit ? acc + 1 : 0);
      check("penable_cycles", pen_n, acc);
      check("apb_ctrl_stable", viol, 0);
      if (!t.wr && !bad) begin
        check("hrdata", fin_rdata, t.rdata);
        exp_hold = t.rdata;
      end
    end
    q.delete();
  endtask

  task automatic idle_check();
    @(negedge Hclk);
    #1;
    check("idle_hreadyout", Hreadyout, 1'b1);
    check("idle_pselx", {Pselx, Penable}, '0);
    check("hrdata_hold", Hrdata, exp_hold);
  endtask

  initial begin
    logic [31:0] a;
    int r, n;
    Hresetn = 1'b0; Htrans = HTRANS_IDLE; Hwrite = 1'b0; Haddr = '0; Hwdata = '0;
    cur_wait = 0; cur_err = 1'b0;
    for (int i = 0; i < NS; i++) slv_data[i] = '0;

    @(negedge Hclk); #1;
    check("rst_hreadyout", Hreadyout, 1'b1);
    check("rst_hresp", Hresp, HRESP_OKAY);
    check("rst_apb_ctrl", {Pselx, Penable, Pwrite}, '0);
    check("rst_paddr", Paddr, '0);
    check("rst_pwdata", Pwdata, '0);
    check("rst_hrdata", Hrdata, '0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    idle_check();

    q.push_back(mk(32'h8000_1004, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF)); run_burst(); idle_check();
    q.push_back(mk(32'h8000_3000, 1'b1, 32'h1234_5678, 0, 1'b0, 32'h0)); run_burst(); idle_check();
    q.push_back(mk(32'h8000_0008, 1'b0, 32'h0, 3, 1'b0, 32'hA5A5_0001)); run_burst(); idle_check();
    q.push_back(mk(32'h8000_2000, 1'b1, 32'hCAFE_0002, 0, 1'b1, 32'h0)); run_burst(); idle_check();
    q.push_back(mk(32'h8000_4000, 1'b0, 32'h0, 0, 1'b0, 32'h0)); run_burst(); idle_check();
    q.push_back(mk(32'h8000_1100, 1'b0, 32'h0, 100, 1'b0, 32'h0)); run_burst(); idle_check();
    q.push_back(mk(32'h8000_0010, 1'b0, 32'h0, 0, 1'b0, 32'h1111_2222));
    q.push_back(mk(32'h8000_1020, 1'b1, 32'h3333_4444, 0, 1'b0, 32'h0));
    q.push_back(mk(32'h8000_2030, 1'b0, 32'h0, 0, 1'b0, 32'h5555_6666));
    run_burst(); idle_check();

    // Asynchronous reset in the middle of an ACCESS phase
    Htrans = HTRANS_NONSEQ; Haddr = 32'h8000_0040; Hwrite = 1'b0;
    @(posedge Hclk);
    @(negedge Hclk);
    Htrans = HTRANS_IDLE; cur_wait = 8; cur_err = 1'b0;
    @(negedge Hclk); #1;
    check("pre_reset_penable", Penable, 1'b1);
    #1 Hresetn = 1'b0;
    #1;
    check("async_rst_apb", {Pselx, Penable}, '0);
    check("async_rst_hreadyout", Hreadyout, 1'b1);
    exp_hold = '0;
    @(negedge Hclk);
    Hresetn = 1'b1; cur_wait = 0;
    #1;
    q.push_back(mk(32'h8000_2ffc, 1'b0, 32'h0, 1, 1'b0, 32'h0BAD_F00D)); run_burst(); idle_check();

    for (int b = 0; b < 40; b++) begin
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        r = $urandom_range(0, 9);
        if (r < 7)       a = BASE + (32'($urandom_range(0, NS - 1)) << 12) + ($urandom & 32'hffc);
        else if (r == 7) a = BASE + (32'(NS) << 12) + ($urandom & 32'hffff);
        else if (r == 8) a = BASE - 32'd4 - ($urandom & 32'hfff0);
        else             a = $urandom;
        q.push_back(mk(a, 1'($urandom), $urandom,
                       ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(TMO, TMO + 2),
                       ($urandom_range(0, 5) == 0), $urandom));
      end
      run_burst();
      idle_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
